// File: rtl/ternary_dot_v3.sv
// Multi-lane ternary dot-product engine: registered lane-sum stage feeding a guard-bit accumulator.
// Optional TDOT_ZSTAT_EN adds a zero-weight lane counter output (zero_count).
module ternary_dot_v3 #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned ACT_BITS   = 16,
    parameter int unsigned ACC_BITS   = 32,
    parameter int unsigned GUARD_BITS = 4,
    parameter int unsigned MAX_BEATS  = 1024,
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
`ifdef TDOT_ZSTAT_EN
    , localparam int unsigned ZC_W    = CNT_W + $clog2(LANES)
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             len,
    input  logic                         sat_en,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*ACT_BITS-1:0]    act,
    input  logic [2*LANES-1:0]           wgt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_BITS-1:0]          result,
    output logic                         sat_flag,
    output logic                         busy
`ifdef TDOT_ZSTAT_EN
    , output logic [ZC_W-1:0]            zero_count
`endif
);

    localparam int unsigned LG   = $clog2(LANES);
    localparam int unsigned LSW  = ACT_BITS + LG + 1;
    localparam int unsigned ACCW = ACC_BITS + GUARD_BITS;
    localparam int unsigned SUMW = ACCW + 1;
    localparam logic signed [SUMW-1:0] SAT_MAX = {{(GUARD_BITS + 2){1'b0}}, {(ACC_BITS - 1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {{(GUARD_BITS + 2){1'b1}}, {(ACC_BITS - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    sat_en_q;
    logic signed [LSW-1:0]   lane_sum_c;
    logic signed [LSW-1:0]   lane_sum;
    logic                    s1_valid;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  acc_nxt_c;
    logic signed [SUMW-1:0]  sum_c;
    logic                    sat_hit_c;
    logic                    accept_c;
    logic                    last_beat_c;

    // Ternary weight selects +act, -act or 0; no multiplier.
    function automatic logic signed [LSW-1:0] lane_prod(input logic signed [ACT_BITS-1:0] a,
                                                        input logic [1:0] w);
        case (w)
            2'b10:   return LSW'(a);
            2'b00:   return -LSW'(a);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        lane_sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_c = lane_sum_c + lane_prod(act[i*ACT_BITS +: ACT_BITS], wgt[2*i +: 2]);
        end
    end

    // Accumulate one extra bit wide so the clamp compare never overflows.
    always_comb begin
        sum_c     = SUMW'(acc) + SUMW'(lane_sum);
        acc_nxt_c = sum_c[ACCW-1:0];
        sat_hit_c = 1'b0;
        if (sat_en_q && (sum_c > SAT_MAX)) begin
            acc_nxt_c = ACCW'(SAT_MAX);
            sat_hit_c = 1'b1;
        end else if (sat_en_q && (sum_c < SAT_MIN)) begin
            acc_nxt_c = ACCW'(SAT_MIN);
            sat_hit_c = 1'b1;
        end
    end

    assign accept_c    = in_valid && in_ready;
    assign last_beat_c = (beat_cnt + CNT_W'(1)) == len_q;

`ifdef TDOT_ZSTAT_EN
    localparam int unsigned ZLW = LG + 1;
    logic [ZLW-1:0] zlanes_c;

    // Weight codes 01 and 11 are the zero weights: bit 0 set.
    always_comb begin
        zlanes_c = '0;
        for (int i = 0; i < LANES; i++) begin
            zlanes_c = zlanes_c + ZLW'(wgt[2*i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_count <= '0;
        end else if (!abort) begin
            if (state == IDLE && start && len != '0) begin
                zero_count <= '0;
            end else if (accept_c) begin
                zero_count <= zero_count + ZC_W'(zlanes_c);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            sat_en_q  <= 1'b0;
            lane_sum  <= '0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            result    <= '0;
            sat_flag  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                in_ready  <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                acc       <= '0;
                beat_cnt  <= '0;
            end else begin
                if (accept_c) begin
                    lane_sum <= lane_sum_c;
                    s1_valid <= 1'b1;
                end
                if (s1_valid) begin
                    acc    <= acc_nxt_c;
                    result <= acc_nxt_c[ACC_BITS-1:0];
                    if (sat_hit_c) sat_flag <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (start && len != '0) begin
                            len_q    <= len;
                            sat_en_q <= sat_en;
                            acc      <= '0;
                            sat_flag <= 1'b0;
                            beat_cnt <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (accept_c) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            if (last_beat_c) begin
                                in_ready <= 1'b0;
                                state    <= DRAIN;
                            end
                        end
                    end
                    // Leave once the final beat has passed stage 1 and landed in acc.
                    DRAIN: begin
                        if (!s1_valid) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ternary_dot_v3.sv
// Scoreboard bench for ternary_dot_v3: default instance plus an ACC_BITS=20 instance for saturation.
module tb_ternary_dot_v3;

    localparam int unsigned LANES    = 8;
    localparam int unsigned ACT_BITS = 16;
    localparam int unsigned CNT_W    = 11;
    localparam int unsigned AW       = LANES * ACT_BITS;
    localparam int unsigned WW       = 2 * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a, start_b;
    logic [CNT_W-1:0] len;
    logic          sat_en, abort, in_valid, out_ready;
    logic [AW-1:0] act;
    logic [WW-1:0] wgt;
    logic          in_ready_a, out_valid_a, sat_flag_a, busy_a;
    logic          in_ready_b, out_valid_b, sat_flag_b, busy_b;
    logic [31:0]   result_a;
    logic [19:0]   result_b;
`ifdef TDOT_ZSTAT_EN
    logic [13:0]   zc_a, zc_b;
`endif

    ternary_dot_v3 #(.LANES(8), .ACT_BITS(16), .ACC_BITS(32), .GUARD_BITS(4), .MAX_BEATS(1024)) dut (
        .clk(clk), .rst(rst), .start(start_a), .len(len), .sat_en(sat_en), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_a), .act(act), .wgt(wgt),
        .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a),
        .sat_flag(sat_flag_a), .busy(busy_a)
`ifdef TDOT_ZSTAT_EN
        , .zero_count(zc_a)
`endif
    );

    ternary_dot_v3 #(.LANES(8), .ACT_BITS(16), .ACC_BITS(20), .GUARD_BITS(4), .MAX_BEATS(1024)) dut20 (
        .clk(clk), .rst(rst), .start(start_b), .len(len), .sat_en(sat_en), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_b), .act(act), .wgt(wgt),
        .out_valid(out_valid_b), .out_ready(out_ready), .result(result_b),
        .sat_flag(sat_flag_b), .busy(busy_b)
`ifdef TDOT_ZSTAT_EN
        , .zero_count(zc_b)
`endif
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        longint res;
        bit     sat;
        longint zc;
        bit     sel;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    bit     cur_sel;
    longint m_acc, m_zc, last_res;
    bit     m_sat, m_sat_en;
    int     m_bits;
    int     last_accept;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit rdy();
        return cur_sel ? in_ready_b : in_ready_a;
    endfunction

    function automatic bit ov();
        return cur_sel ? out_valid_b : out_valid_a;
    endfunction

    function automatic longint beat_sum(input logic [AW-1:0] a, input logic [WW-1:0] w);
        longint s;
        logic signed [ACT_BITS-1:0] v;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            v = a[i*ACT_BITS +: ACT_BITS];
            if (w[2*i +: 2] == 2'b10) s = s + v;
            else if (w[2*i +: 2] == 2'b00) s = s - v;
        end
        return s;
    endfunction

    function automatic int zeros(input logic [WW-1:0] w);
        int z;
        z = 0;
        for (int i = 0; i < LANES; i++) if (w[2*i +: 2] == 2'b01 || w[2*i +: 2] == 2'b11) z++;
        return z;
    endfunction

    function automatic logic [AW-1:0] rand_act();
        logic [AW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*ACT_BITS +: ACT_BITS] = 16'($urandom);
        return r;
    endfunction

    task automatic op_start(input bit sel, input int l, input bit s);
        @(negedge clk);
        len    = CNT_W'(l);
        sat_en = s;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        start_b  = 1'b0;
        cur_sel  = sel;
        m_acc    = 0;
        m_zc     = 0;
        m_sat    = 1'b0;
        m_sat_en = s;
        m_bits   = sel ? 20 : 32;
    endtask

    task automatic send_beat(input logic [AW-1:0] a, input logic [WW-1:0] w, input int gap);
        int n;
        longint one, maxv, minv;
        one = 1;
        act = a; wgt = w; in_valid = 1'b1; n = 0;
        while (!rdy() && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy()) begin
            check("in_ready_wait", rdy(), 1);
        end else begin
            last_accept = cycle + 1;
            maxv  = (one << (m_bits - 1)) - 1;
            minv  = -(one << (m_bits - 1));
            m_acc = m_acc + beat_sum(a, w);
            m_zc  = m_zc + zeros(w);
            if (m_sat_en && m_acc > maxv) begin m_acc = maxv; m_sat = 1'b1; end
            if (m_sat_en && m_acc < minv) begin m_acc = minv; m_sat = 1'b1; end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic op_push();
        exp_t e;
        longint one, md, r;
        one = 1;
        md  = one << m_bits;
        r   = m_acc & (md - 1);
        if (r >= (one << (m_bits - 1))) r = r - md;
        e.res = r; e.sat = m_sat; e.zc = m_zc; e.sel = cur_sel;
        sb.push_back(e);
    endtask

    task automatic get_result(input string tag, input bit chk_lat);
        int n;
        exp_t e;
        n = 0;
        while (!ov() && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, ov(), 1);
        if (ov()) begin
            check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                last_res = e.res;
                check({tag, "_result"}, e.sel ? 64'($signed(result_b)) : 64'($signed(result_a)), e.res);
                check({tag, "_sat_flag"}, e.sel ? sat_flag_b : sat_flag_a, e.sat);
`ifdef TDOT_ZSTAT_EN
                check({tag, "_zero_count"}, e.sel ? 64'(zc_b) : 64'(zc_a), e.zc);
`endif
                if (chk_lat) check({tag, "_latency"}, cycle - last_accept, 2);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        int seen, l;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; len = '0; sat_en = 1'b0; abort = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; act = '0; wgt = '0; cur_sel = 1'b0; last_res = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_result", result_a, 0);
        check("rst_sat_flag", sat_flag_a, 0);
        check("rst_busy", busy_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // len=1, all +1 weights on act=100
        op_start(0, 1, 0);
        check("t1_busy", busy_a, 1);
        send_beat({8{16'd100}}, 16'hAAAA, 0);
        op_push();
        get_result("t1", 1);

        // alternating +1/-1 on act=i+1, gaps between beats
        for (int i = 0; i < LANES; i++) a[i*ACT_BITS +: ACT_BITS] = 16'(i + 1);
        op_start(0, 3, 0);
        send_beat(a, 16'h2222, 2);
        send_beat(a, 16'h2222, 2);
        send_beat(a, 16'h2222, 0);
        op_push();
        get_result("t2", 1);

        // 20-bit result: saturating then wrapping
        op_start(1, 3, 1);
        repeat (3) send_beat({8{16'h7FFF}}, 16'hAAAA, 0);
        op_push();
        get_result("t3_sat", 1);
        op_start(1, 3, 0);
        repeat (3) send_beat({8{16'h7FFF}}, 16'hAAAA, 0);
        op_push();
        get_result("t3_wrap", 1);

        // DONE held by out_ready low; start pulses must be ignored
        out_ready = 1'b0;
        op_start(0, 2, 1);
        send_beat(rand_act(), 16'($urandom), 0);
        send_beat(rand_act(), 16'($urandom), 0);
        op_push();
        get_result("t4", 1);
        for (int k = 0; k < 5; k++) begin
            len = CNT_W'(1);
            start_a = (k == 2);
            @(negedge clk);
            check("t4_hold_result", 64'($signed(result_a)), last_res);
            check("t4_hold_in_ready", in_ready_a, 0);
            check("t4_hold_out_valid", out_valid_a, 1);
            check("t4_hold_busy", busy_a, 1);
        end
        start_a = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_release_out_valid", out_valid_a, 0);
        check("t4_release_busy", busy_a, 0);

        // abort after 2 of 4 beats
        op_start(0, 4, 0);
        send_beat(rand_act(), 16'($urandom), 0);
        send_beat(rand_act(), 16'($urandom), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy", busy_a, 0);
        check("t5_abort_in_ready", in_ready_a, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_a) seen = 1;
        end
        check("t5_abort_no_out_valid", seen, 0);
        a = rand_act();
        a[ACT_BITS-1:0] = 16'd5;
        op_start(0, 1, 0);
        send_beat(a, 16'h5554, 0);
        op_push();
        get_result("t5_new", 1);

        // reset mid-ACCUM clears outputs immediately
        op_start(0, 4, 1);
        send_beat(rand_act(), 16'($urandom), 0);
        rst = 1'b1;
        #1;
        check("t5_rst_in_ready", in_ready_a, 0);
        check("t5_rst_out_valid", out_valid_a, 0);
        check("t5_rst_result", result_a, 0);
        check("t5_rst_sat_flag", sat_flag_a, 0);
        check("t5_rst_busy", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // all-zero weights (codes 01 and 11)
        op_start(0, 4, 0);
        send_beat(rand_act(), 16'hDDDD, 0);
        send_beat(rand_act(), 16'h7575, 0);
        send_beat(rand_act(), 16'h5555, 0);
        send_beat(rand_act(), 16'hFFFF, 0);
        op_push();
        get_result("t6", 1);

        // random operations
        for (int r = 0; r < 4; r++) begin
            l = int'($urandom_range(5, 1));
            op_start(0, l, 1'($urandom));
            for (int b = 0; b < l; b++) begin
                w = 16'($urandom);
                send_beat(rand_act(), w, (b == l - 1) ? 0 : int'($urandom_range(1, 0)));
            end
            op_push();
            get_result("rnd", 1);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
